// File: rtl/hack_cpu_ctrl_if.sv
// Hack control unit bus: instruction fetch, ALU flags, datapath controls.
// master = control unit side, slave = ROM/datapath side.
interface hack_cpu_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
);
    logic [WIDTH-1:0] instr_i;
    logic             instr_valid_i;
    logic             zr_i;
    logic             ng_i;
    logic             fetch_req_o;
    logic             pc_rst_o;
    logic             pc_load_o;
    logic             pc_inc_o;
    logic             a_load_o;
    logic             a_sel_o;
    logic             d_load_o;
    logic             m_write_o;
    logic             am_sel_o;
    logic             zx_o;
    logic             nx_o;
    logic             zy_o;
    logic             ny_o;
    logic             f_o;
    logic             no_o;
    logic [CNT_W-1:0] retired_o;
`ifdef HACK_CTRL_HALT_EN
    logic             halt_i;
    logic             halted_o;
`endif

    modport master (
        input  instr_i, instr_valid_i, zr_i, ng_i,
`ifdef HACK_CTRL_HALT_EN
        input  halt_i,
        output halted_o,
`endif
        output fetch_req_o, pc_rst_o, pc_load_o, pc_inc_o,
        output a_load_o, a_sel_o, d_load_o, m_write_o, am_sel_o,
        output zx_o, nx_o, zy_o, ny_o, f_o, no_o,
        output retired_o
    );

    modport slave (
        output instr_i, instr_valid_i, zr_i, ng_i,
`ifdef HACK_CTRL_HALT_EN
        output halt_i,
        input  halted_o,
`endif
        input  fetch_req_o, pc_rst_o, pc_load_o, pc_inc_o,
        input  a_load_o, a_sel_o, d_load_o, m_write_o, am_sel_o,
        input  zx_o, nx_o, zy_o, ny_o, f_o, no_o,
        input  retired_o
    );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack control unit: RST -> FETCH -> DECODE -> EXEC -> FETCH.
// Ports: clk_i, rst_ni (async, active low), bus (hack_cpu_ctrl_if.master).
// Optional HACK_CTRL_HALT_EN adds halt_i/halted_o and a HALT state.
module hack_cpu_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    hack_cpu_ctrl_if.master       bus
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3
`ifdef HACK_CTRL_HALT_EN
        ,S_HALT  = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q;
    logic [CNT_W-1:0] ret_q;

    logic is_c;
    logic take;
    logic fetch_req, pc_rst, pc_load, pc_inc;
    logic a_load, a_sel, d_load, m_write, am_sel;
    logic [5:0] alu;
    logic halt_req;

    // ir[14:13] carry no meaning in a C-instruction
    logic unused_ir;
    assign unused_ir = ^ir_q[14:13];

`ifdef HACK_CTRL_HALT_EN
    assign halt_req = bus.halt_i;
`else
    assign halt_req = 1'b0;
`endif

    assign is_c = ir_q[15];
    assign take = (ir_q[2] & bus.ng_i)
                | (ir_q[1] & bus.zr_i)
                | (ir_q[0] & ~bus.ng_i & ~bus.zr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_q  <= '0;
            ret_q <= '0;
        end else begin
            if (state_q == S_FETCH && bus.instr_valid_i && !halt_req)
                ir_q <= bus.instr_i;
            if (state_q == S_EXEC)
                ret_q <= ret_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (halt_req) begin
`ifdef HACK_CTRL_HALT_EN
                    state_d = S_HALT;
`endif
                end else if (bus.instr_valid_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_FETCH;
`ifdef HACK_CTRL_HALT_EN
            S_HALT: begin
                if (!halt_req)
                    state_d = S_FETCH;
            end
`endif
            default:  state_d = S_RST;
        endcase
    end

    always_comb begin
        fetch_req = 1'b0;
        pc_rst    = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        a_load    = 1'b0;
        a_sel     = 1'b0;
        d_load    = 1'b0;
        m_write   = 1'b0;
        am_sel    = 1'b0;
        alu       = 6'b0;
        unique case (state_q)
            S_RST:   pc_rst = 1'b1;
            S_FETCH: fetch_req = 1'b1;
            S_DECODE: begin
                if (is_c) begin
                    am_sel = ir_q[12];
                    alu    = ir_q[11:6];
                end
            end
            S_EXEC: begin
                if (is_c) begin
                    am_sel  = ir_q[12];
                    alu     = ir_q[11:6];
                    a_load  = ir_q[5];
                    a_sel   = ir_q[5];
                    d_load  = ir_q[4];
                    m_write = ir_q[3];
                    pc_load = take;
                    pc_inc  = ~take;
                end else begin
                    a_load = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.fetch_req_o = fetch_req;
    assign bus.pc_rst_o    = pc_rst;
    assign bus.pc_load_o   = pc_load;
    assign bus.pc_inc_o    = pc_inc;
    assign bus.a_load_o    = a_load;
    assign bus.a_sel_o     = a_sel;
    assign bus.d_load_o    = d_load;
    assign bus.m_write_o   = m_write;
    assign bus.am_sel_o    = am_sel;
    assign bus.zx_o        = alu[5];
    assign bus.nx_o        = alu[4];
    assign bus.zy_o        = alu[3];
    assign bus.ny_o        = alu[2];
    assign bus.f_o         = alu[1];
    assign bus.no_o        = alu[0];
    assign bus.retired_o   = ret_q;
`ifdef HACK_CTRL_HALT_EN
    assign bus.halted_o    = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Randomized self-checking bench for hack_cpu_ctrl.
// Uses CNT_W=4 so retired counter wrap is reached quickly.
module tb_hack_cpu_ctrl;

    localparam int CW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   model_ret;

    hack_cpu_ctrl_if #(.WIDTH(16), .CNT_W(CW)) b ();

    hack_cpu_ctrl #(.WIDTH(16), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (b.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [14:0] act();
        return {b.fetch_req_o, b.pc_rst_o, b.pc_load_o, b.pc_inc_o,
                b.a_load_o, b.a_sel_o, b.d_load_o, b.m_write_o,
                b.am_sel_o, b.zx_o, b.nx_o, b.zy_o, b.ny_o,
                b.f_o, b.no_o};
    endfunction

    // phase: 0 fetch, 1 decode, 2 exec, 3 reset
    function automatic logic [14:0] model(int phase, int ins,
                                          bit zr, bit ng);
        logic [14:0] v;
        int dest;
        int j;
        bit tk;
        v = '0;
        if (phase == 0) v[14] = 1'b1;
        if (phase == 3) v[13] = 1'b1;
        if ((phase == 1 || phase == 2) && ins >= 32768) begin
            v[6]   = 1'((ins / 4096) % 2);
            v[5:0] = 6'((ins / 64) % 64);
        end
        if (phase == 2) begin
            if (ins >= 32768) begin
                dest = (ins / 8) % 8;
                j    = ins % 8;
                tk   = (j >= 4 && ng)
                    || ((j / 2) % 2 == 1 && zr)
                    || (j % 2 == 1 && !ng && !zr);
                v[10] = 1'(dest / 4);
                v[9]  = 1'(dest / 4);
                v[8]  = 1'((dest / 2) % 2);
                v[7]  = 1'(dest % 2);
                v[12] = tk;
                v[11] = !tk;
            end else begin
                v[10] = 1'b1;
                v[11] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic do_instr(input int ins, input bit zr,
                            input bit ng, input int gap,
                            input string nm);
        logic [14:0] e;
        for (int g = 0; g < gap; g++) begin
            #1;
            e = model(0, 0, 0, 0);
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL %s idle%0d got %h exp %h", nm, g, act(), e);
            end
            @(negedge clk);
        end
        #1;
        e = model(0, 0, 0, 0);
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL %s fetch got %h exp %h", nm, act(), e);
        end
        b.instr_i = 16'(ins);
        b.instr_valid_i = 1'b1;
        @(negedge clk);
        b.instr_valid_i = 1'($urandom);
        b.instr_i = 16'($urandom);
        #1;
        e = model(1, ins, zr, ng);
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL %s decode got %h exp %h", nm, act(), e);
        end
        b.zr_i = zr;
        b.ng_i = ng;
        @(negedge clk);
        b.instr_valid_i = 1'($urandom);
        #1;
        e = model(2, ins, zr, ng);
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL %s exec got %h exp %h", nm, act(), e);
        end
        @(negedge clk);
        b.instr_valid_i = 1'b0;
        model_ret = (model_ret + 1) % (1 << CW);
        #1;
        checks++;
        if (b.retired_o !== CW'(model_ret)) begin
            errors++;
            $display("FAIL %s retired got %0d exp %0d",
                     nm, b.retired_o, model_ret);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [14:0] e;
        rst_n = 1'b0;
        #12;
        e = model(3, 0, 0, 0);
        checks++;
        if (act() !== e || b.retired_o !== '0) begin
            errors++;
            $display("FAIL reset got %h/%0d exp %h/0",
                     act(), b.retired_o, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL rst_state got %h exp %h", act(), e);
        end
        @(negedge clk);
        #1;
        e = model(0, 0, 0, 0);
        checks++;
        if (act() !== e || b.retired_o !== '0) begin
            errors++;
            $display("FAIL first_fetch got %h/%0d exp %h/0",
                     act(), b.retired_o, e);
        end
        model_ret = 0;
    endtask

    task automatic test_directed();
        do_instr(16'h0015, 0, 0, 0, "a_instr");
        do_instr(16'hFC10, 0, 0, 0, "d_eq_m");
        do_instr(16'hE302, 1, 0, 1, "jeq_taken");
        do_instr(16'hE302, 0, 0, 0, "jeq_not");
        do_instr(16'hEA87, 0, 1, 0, "jmp_ng");
        do_instr(16'hEA87, 1, 0, 0, "jmp_zr");
        do_instr(16'hEA87, 0, 0, 0, "jmp_pos");
        do_instr(16'hE000, 0, 1, 0, "nodest_nojmp");
        do_instr(16'h7FFF, 1, 0, 5, "a_stall5");
    endtask

    task automatic test_random();
        int ins;
        bit zr;
        bit ng;
        for (int i = 0; i < 40; i++) begin
            ins = int'($urandom_range(0, 65535));
            zr  = 1'($urandom);
            ng  = zr ? 1'b0 : 1'($urandom);
            do_instr(ins, zr, ng, int'($urandom_range(0, 2)), "rand");
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [14:0] e;
        #1;
        b.instr_i = 16'hE318;
        b.instr_valid_i = 1'b1;
        @(negedge clk);
        b.instr_valid_i = 1'b0;
        @(negedge clk);
        #1;
        e = model(2, 16'hE318, 0, 0);
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL mid_exec got %h exp %h", act(), e);
        end
        rst_n = 1'b0;
        model_ret = 0;
        #1;
        e = model(3, 0, 0, 0);
        checks++;
        if (act() !== e || b.retired_o !== '0) begin
            errors++;
            $display("FAIL abort got %h/%0d exp %h/0",
                     act(), b.retired_o, e);
        end
        @(posedge clk);
        #1;
        checks++;
        if (act() !== e || b.retired_o !== '0) begin
            errors++;
            $display("FAIL abort_edge got %h/%0d exp %h/0",
                     act(), b.retired_o, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        e = model(0, 0, 0, 0);
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL restart got %h exp %h", act(), e);
        end
        @(negedge clk);
        do_instr(16'hE318, 0, 0, 0, "after_abort");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_ret = 0;
        rst_n = 1'b0;
        b.instr_i = '0;
        b.instr_valid_i = 1'b0;
        b.zr_i = 1'b0;
        b.ng_i = 1'b0;
`ifdef HACK_CTRL_HALT_EN
        b.halt_i = 1'b0;
`endif
        test_reset();
        @(negedge clk);
        test_directed();
        test_random();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
